// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel glitch-free programmable clock divider
// Optional phase-align input sync_req is built when CLKDIV_PHASE_SYNC_EN is defined.
module clk_div_bank #(
  parameter  int NCH = 4,
  parameter  int CW  = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           sysclk,
  input  logic           rst,
  input  logic [NCH-1:0] enable,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic           sync_req,
`endif
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_mode,
  output logic [NCH-1:0] out_clk,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [NCH-1:0]        pending;
  logic [(1<<CHW)-1:0]   pend_ext;
  logic                  sync;

  // Out-of-range channel indices (NCH not a power of two) read as never pending.
  always_comb begin
    pend_ext = '0;
    pend_ext[NCH-1:0] = pending;
  end

  assign cfg_ready = ~pend_ext[cfg_ch];

`ifdef CLKDIV_PHASE_SYNC_EN
  assign sync = sync_req;
`else
  assign sync = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] act_div;
    logic [CW-1:0] sh_div;
    logic          act_mode;
    logic          sh_mode;
    logic          oc;
    logic          tk;
    logic          pd;
    logic          wr;
    logic          term;

    assign wr         = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));
    assign term       = (cnt == act_div);
    assign out_clk[i] = oc;
    assign tick[i]    = tk;
    assign pending[i] = pd;
    assign busy[i]    = (state != ST_IDLE);

    always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        act_div  <= '0;
        sh_div   <= '0;
        act_mode <= 1'b0;
        sh_mode  <= 1'b0;
        oc       <= 1'b0;
        tk       <= 1'b0;
        pd       <= 1'b0;
      end else begin
        tk <= 1'b0;
        if (sync && (state != ST_IDLE)) begin
          // Phase align: restart from zero with no tick, even on a terminal cycle.
          cnt   <= '0;
          oc    <= 1'b0;
          state <= (state == ST_RUN && enable[i]) ? ST_RUN : ST_IDLE;
          if (pd) begin
            act_div  <= sh_div;
            act_mode <= sh_mode;
            pd       <= 1'b0;
          end
        end else begin
          case (state)
            ST_IDLE: begin
              cnt <= '0;
              oc  <= 1'b0;
              if (enable[i]) begin
                state <= ST_RUN;
                if (pd) begin
                  act_div  <= sh_div;
                  act_mode <= sh_mode;
                  pd       <= 1'b0;
                end
              end
            end
            ST_RUN, ST_STOP: begin
              if (state == ST_RUN && !enable[i] && !oc) begin
                state <= ST_IDLE;
                cnt   <= '0;
              end else begin
                if (term) begin
                  cnt <= '0;
                  tk  <= 1'b1;
                  if (pd) begin
                    act_div  <= sh_div;
                    act_mode <= sh_mode;
                    pd       <= 1'b0;
                  end
                  if (state == ST_STOP && !enable[i]) begin
                    oc    <= 1'b0;
                    state <= ST_IDLE;
                  end else begin
                    oc <= act_mode | ~oc;
                  end
                end else begin
                  cnt <= cnt + 1'b1;
                  if (act_mode) oc <= 1'b0;
                end
                // A high output must finish its period before the channel idles.
                if (state == ST_RUN && !enable[i]) state <= ST_STOP;
                if (state == ST_STOP && enable[i]) state <= ST_RUN;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
        if (wr) begin
          if (state == ST_IDLE) begin
            act_div  <= cfg_div;
            act_mode <= cfg_mode;
          end else begin
            sh_div  <= cfg_div;
            sh_mode <= cfg_mode;
            pd      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed self-checking bench for clk_div_bank
module tb_clk_div_bank;

  logic       sysclk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] enable = 4'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_mode = 1'b0;
  logic [3:0] out_clk;
  logic [3:0] tick;
  logic [3:0] busy;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic       sync_req = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  clk_div_bank #(.NCH(4), .CW(8)) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .enable    (enable),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync_req  (sync_req),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .out_clk   (out_clk),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] div, input logic mode);
    cfg_ch    = ch;
    cfg_div   = div;
    cfg_mode  = mode;
    cfg_valid = 1'b1;
    check("cfg_ready_idle", 32'(cfg_ready), 32'(1));
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic eo, et, eo1, et1;

    // Reset state
    #12;
    check("rst_outputs", 32'({out_clk, tick, busy}), 32'(0));
    check("rst_ready", 32'(cfg_ready), 32'(1));
    @(negedge sysclk);
    rst = 1'b1;
    cyc();

    // ch0 D=3 toggle: period 8, tick every 4
    cfg_write(2'd0, 8'd3, 1'b0);
    enable[0] = 1'b1;
    cyc();
    check("t1_start", 32'({busy[0], out_clk[0]}), 32'(2'b10));
    for (int k = 1; k <= 16; k++) begin
      cyc();
      eo = ((k / 4) % 2 == 1);
      et = (k % 4 == 0);
      check("t1_wave", 32'({out_clk[0], tick[0]}), 32'({eo, et}));
    end
    enable[0] = 1'b0;
    cyc();
    check("t1_idle_low", 32'({busy[0], out_clk[0]}), 32'(0));

    // ch1 D=1 pulse, retarget to D=4 mid-count
    cfg_write(2'd1, 8'd1, 1'b1);
    enable[1] = 1'b1;
    cyc();
    cyc();
    cyc();
    check("t2_old_pulse", 32'({out_clk[1], tick[1]}), 32'(2'b11));
    cfg_ch    = 2'd1;
    cfg_div   = 8'd4;
    cfg_mode  = 1'b1;
    cfg_valid = 1'b1;
    check("t2_ready_before", 32'(cfg_ready), 32'(1));
    cyc();
    check("t2_stall", 32'(cfg_ready), 32'(0));
    check("t2_mid_low", 32'(out_clk[1]), 32'(0));
    cfg_valid = 1'b0;
    cyc();
    check("t2_apply_pulse", 32'({out_clk[1], tick[1], cfg_ready}), 32'(3'b111));
    for (int k = 5; k <= 14; k++) begin
      cyc();
      eo = (k == 9 || k == 14);
      check("t2_new_spacing", 32'({out_clk[1], tick[1]}), 32'({eo, eo}));
    end
    cyc();
    enable[1] = 1'b0;
    cyc();
    check("t2_idle", 32'(busy[1]), 32'(0));

    // ch2 D=5 toggle, drop enable while high -> STOP
    cfg_write(2'd2, 8'd5, 1'b0);
    enable[2] = 1'b1;
    cyc();
    for (int k = 1; k <= 6; k++) cyc();
    check("t3_first_high", 32'({out_clk[2], tick[2]}), 32'(2'b11));
    enable[2] = 1'b0;
    cyc();
    check("t3_stop", 32'({busy[2], out_clk[2]}), 32'(2'b11));
    for (int k = 8; k <= 11; k++) cyc();
    check("t3_stop_hold", 32'({busy[2], out_clk[2], tick[2]}), 32'(3'b110));
    cyc();
    check("t3_stop_end", 32'({out_clk[2], tick[2], busy[2]}), 32'(3'b010));
    cyc();
    check("t3_after", 32'({out_clk[2], tick[2], busy[2]}), 32'(0));

    // ch0 D=0 toggle mode: sysclk/2
    cfg_write(2'd0, 8'd0, 1'b0);
    enable[0] = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      eo = (k % 2 == 1);
      check("t4_div2", 32'({out_clk[0], tick[0]}), 32'({eo, 1'b1}));
    end
    enable[0] = 1'b0;
    cyc();
    check("t4_idle", 32'(busy[0]), 32'(0));

    // ch0 D=0 pulse mode: constant high
    cfg_write(2'd0, 8'd0, 1'b1);
    enable[0] = 1'b1;
    cyc();
    check("t4_pulse_start", 32'(out_clk[0]), 32'(0));
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("t4_const_high", 32'({out_clk[0], tick[0]}), 32'(2'b11));
    end
    enable[0] = 1'b0;
    cyc();
    check("t4_stop", 32'({out_clk[0], tick[0], busy[0]}), 32'(3'b111));
    cyc();
    check("t4_stop_end", 32'({out_clk[0], tick[0], busy[0]}), 32'(3'b010));

    // ch3 write while IDLE takes effect directly
    cfg_ch    = 2'd3;
    cfg_div   = 8'd2;
    cfg_mode  = 1'b1;
    cfg_valid = 1'b1;
    check("t5_ready_before", 32'(cfg_ready), 32'(1));
    cyc();
    check("t5_ready_after", 32'(cfg_ready), 32'(1));
    cfg_valid = 1'b0;
    enable[3] = 1'b1;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      eo = (k % 3 == 0);
      check("t5_pulse", 32'(out_clk[3]), 32'(eo));
    end

    // Async reset with ch1 pending
    enable[1] = 1'b1;
    cyc();
    cyc();
    cfg_ch    = 2'd1;
    cfg_div   = 8'd7;
    cfg_mode  = 1'b0;
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    check("t6_pending", 32'(cfg_ready), 32'(0));
    check("t6_busy_pre", 32'(busy), 32'(4'b1010));
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_clear", 32'({out_clk, tick, busy}), 32'(0));
    check("t6_ready_clear", 32'(cfg_ready), 32'(1));
    enable = 4'b0010;
    @(negedge sysclk);
    rst = 1'b1;
    cyc();
    check("t6_restart", 32'({busy, out_clk[1]}), 32'(5'b00100));
    for (int k = 1; k <= 3; k++) begin
      cyc();
      eo = (k % 2 == 1);
      check("t6_default_div", 32'({out_clk[1], tick[1]}), 32'({eo, 1'b1}));
    end

`ifdef CLKDIV_PHASE_SYNC_EN
    // Phase sync overrides a coincident terminal
    rst = 1'b0;
    enable = 4'b0;
    #2;
    @(negedge sysclk);
    rst = 1'b1;
    cfg_write(2'd0, 8'd2, 1'b0);
    cfg_write(2'd1, 8'd6, 1'b0);
    enable = 4'b0011;
    cyc();
    cyc();
    cyc();
    sync_req = 1'b1;
    cyc();
    sync_req = 1'b0;
    check("t7_sync", 32'({out_clk[1:0], tick[1:0]}), 32'(0));
    for (int k = 1; k <= 7; k++) begin
      cyc();
      eo  = (k >= 3 && k <= 5);
      et  = (k == 3 || k == 6);
      eo1 = (k == 7);
      et1 = (k == 7);
      check("t7_align", 32'({out_clk[1], out_clk[0], tick[1], tick[0]}), 32'({eo1, eo, et1, et}));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock divider. All channels run from a single sysclk.
- Each channel has its own divisor and output mode.
- Configuration is written through a valid/ready port and takes effect only at the channel's terminal count, so outputs never glitch.
- Replaces per-design single-channel dividers in the clock/timing subsystem. Consumers use out_clk as a slow clock and tick as a clock-enable.

Parameters:
- NCH, 4: number of divider channels, 1..16.
- CW, 8: divisor/counter width in bits, 2..16.
- CHW, $clog2(NCH) (min 1): channel index width; derived, not overridden.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- enable  in  NCH  per-channel run request, level.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready at posedge.
- cfg_ch  in  CHW  target channel.
- cfg_div  in  CW  terminal count D; channel period base is D+1 sysclk cycles.
- cfg_mode  in  1  0 = toggle (50% duty), 1 = pulse.
- out_clk  out  NCH  divided outputs, registered.
- tick  out  NCH  one-cycle pulse at each channel terminal count, registered.
- busy  out  NCH  1 while a channel is RUN or STOP.

Behaviour:
- Reset state (rst low, async):
  - all counters 0; out_clk = 0; tick = 0; busy = 0.
  - active div/mode and shadow div/mode = 0; pending = 0; all channels IDLE.
- Per-channel state machine:
  - IDLE: counter held 0, out_clk 0. On enable=1, go to RUN the next cycle with counter = 0. Pending shadow values are applied on entry to RUN.
  - RUN: counter increments each cycle. When counter == active div (terminal):
    - counter goes to 0 and tick pulses for one cycle.
    - mode 0: out_clk toggles, giving period 2*(D+1) cycles.
    - mode 1: out_clk = 1 for exactly that cycle, giving period D+1.
    - If pending, shadow is copied to active in the same cycle and pending clears; new values govern from counter = 0.
    - enable=0 in RUN: if out_clk=0, go to IDLE the next cycle. Otherwise go to STOP.
  - STOP: keep counting with unchanged div. At the next terminal, out_clk goes to 0, tick pulses, and the channel goes to IDLE. enable re-asserted in STOP returns to RUN without disturbing the counter or output.
- Special divisor values:
  - D = 0, mode 0: out_clk toggles every cycle (sysclk/2).
  - D = 0, mode 1: out_clk held 1 continuously and tick held 1.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - Accepted write to an IDLE channel loads active directly; no pending is set.
  - Accepted write to a RUN/STOP channel loads shadow and sets pending.
  - A second write to a channel that is pending is stalled (ready=0) until its terminal.
  - Write accepted in the same cycle as that channel's terminal: the terminal applies the old pending (if any) first, the new write then becomes pending. With pending=0 it is simply pending for the next terminal.
- Counter compare is equality. On apply, a counter above the new D cannot occur because the counter is 0.
- out_clk and tick are flop outputs; latency from enable rising to first counter increment is 1 cycle.
- Reset mid-operation: immediate return to the reset state, including loss of pending configuration.

Optional Feature:
- Macro CLKDIV_PHASE_SYNC_EN.
- Defined:
  - Adds input sync_req (1 bit).
  - A cycle with sync_req=1 forces every RUN channel to counter = 0 and out_clk = 0 next cycle, with no tick. This phase-aligns all channels.
  - STOP channels go to IDLE; IDLE channels are unaffected.
  - Pending configs are applied by the sync.
  - sync_req takes priority over a terminal in the same cycle.
- Undefined: port absent, no sync logic.

Test Plan:
- Reset, then enable[0]=1 with D=3, mode 0 -> out_clk[0] period 8 cycles, high 4/low 4; tick[0] every 4 cycles; busy[0]=1.
- Ch1 running D=1 mode 1; write D=4 mid-count -> cfg_ready low for ch1 until terminal; pulse spacing switches from 2 to 5 at exactly the terminal, with no short pulse.
- Ch2 mode 0 D=5; drop enable while out_clk=1 -> STOP; out_clk falls at the next terminal, then IDLE with busy=0. Drop enable while out_clk=0 -> IDLE the next cycle.
- D=0 on ch0 mode 0 / mode 1 -> sysclk/2 toggle / constant 1; write to ch3 while IDLE -> cfg_ready stays 1 and active updates immediately.
- Assert rst mid-run with ch1 pending -> all outputs 0 asynchronously; after release, ch1 runs with D=0, mode 0.
- With CLKDIV_PHASE_SYNC_EN: ch0 D=2, ch1 D=6, sync_req pulse -> both restart at counter 0 the same cycle; first toggles at +3 and +7 cycles.
